// File: rtl/apb_logic_unit_pkg.sv
// Shared types and constants for the APB logic unit: opcodes, register map,
// STATUS bit positions and FSM state encoding.
package apb_logic_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_NAND = 4'd4,
    OP_NOR  = 4'd5,
    OP_XNOR = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8,
    OP_NOT  = 4'd9
  } opcode_e;

  localparam logic [4:0] OFF_OP_A   = 5'h00;
  localparam logic [4:0] OFF_OP_B   = 5'h04;
  localparam logic [4:0] OFF_RESULT = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam int unsigned ST_BUSY_BIT  = 0;
  localparam int unsigned ST_DONE_BIT  = 1;
  localparam int unsigned ST_CARRY_BIT = 2;
  localparam int unsigned ST_OPERR_BIT = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    DONE = S_DONE
  } fsm_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_AND) && (op <= OP_NOT);
  endfunction

  function automatic logic [2:0] reg_index(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/apb_logic_unit_core.sv
// Combinational evaluation of one opcode over two operands; result wraps
// modulo 2^DATA_W, carry is ADD carry-out or SUB borrow.
module apb_logic_unit_core
  import apb_logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  // The extra top bit of the widened subtraction is the borrow.
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_NAND: result = ~(op_a & op_b);
      OP_NOR:  result = ~(op_a | op_b);
      OP_XNOR: result = ~(op_a ^ op_b);
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_NOT:  result = ~op_a;
      default: ;
    endcase
  end

endmodule

// File: rtl/apb_logic_unit.sv
// APB slave wrapping the logic core: register map, error decode, busy/done
// FSM with a latency counter, and PREADY stalls on early RESULT reads.
module apb_logic_unit
  import apb_logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  fsm_e              state;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic [3:0]        ctrl_op;
  logic              carry, op_err;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] core_res;
  logic              core_carry;

  logic              access, upper_zero, addr_ok, stall, commit, wr, rd;
  logic [2:0]        reg_idx;
  logic              sel_op_a, sel_op_b, sel_result, sel_ctrl, sel_status;
  logic              new_op_legal, err, start, set_op_err;
  logic [DATA_W-1:0] rdata, status_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  assign access     = PSEL & PENABLE;
  assign upper_zero = (PADDR >> 5) == '0;
  assign reg_idx    = PADDR[4:2];
  assign addr_ok    = upper_zero && (reg_idx <= reg_index(OFF_STATUS));

  assign sel_op_a   = addr_ok && (reg_idx == reg_index(OFF_OP_A));
  assign sel_op_b   = addr_ok && (reg_idx == reg_index(OFF_OP_B));
  assign sel_result = addr_ok && (reg_idx == reg_index(OFF_RESULT));
  assign sel_ctrl   = addr_ok && (reg_idx == reg_index(OFF_CTRL));
  assign sel_status = addr_ok && (reg_idx == reg_index(OFF_STATUS));

  assign stall   = access && !PWRITE && sel_result && (state == BUSY);
  assign PREADY  = !stall;
  assign commit  = access && !stall;
  assign wr      = commit && PWRITE;
  assign rd      = commit && !PWRITE;

  assign new_op_legal = op_is_legal(PWDATA[3:0]);

  always_comb begin
    err = 1'b0;
    if (!addr_ok)
      err = 1'b1;
    else if (PWRITE && (sel_result || sel_status))
      err = 1'b1;
    else if (PWRITE && sel_ctrl && ((state == BUSY) || !new_op_legal))
      err = 1'b1;
  end

  assign PSLVERR    = commit && err;
  assign start      = wr && sel_ctrl && (state != BUSY) && new_op_legal;
  // A CTRL write rejected for being busy leaves op_err alone; only a bad opcode flags it.
  assign set_op_err = wr && sel_ctrl && (state != BUSY) && !new_op_legal;

  always_comb begin
    status_word               = '0;
    status_word[ST_BUSY_BIT]  = (state == BUSY);
    status_word[ST_DONE_BIT]  = (state == DONE);
    status_word[ST_CARRY_BIT] = carry;
    status_word[ST_OPERR_BIT] = op_err;
  end

  always_comb begin
    rdata = '0;
    if (sel_op_a)
      rdata = op_a;
    else if (sel_op_b)
      rdata = op_b;
    else if (sel_result)
      rdata = result;
    else if (sel_ctrl)
      rdata[3:0] = ctrl_op;
    else if (sel_status)
      rdata = status_word;
  end

  assign PRDATA = rd ? rdata : '0;

  apb_logic_unit_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .opcode(ctrl_op),
    .op_a  (lat_a),
    .op_b  (lat_b),
    .result(core_res),
    .carry (core_carry)
  );

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
      ctrl_op <= '0;
      carry   <= 1'b0;
      op_err  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (wr && sel_op_a)
        op_a <= PWDATA;
      if (wr && sel_op_b)
        op_b <= PWDATA;
      if (set_op_err)
        op_err <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            ctrl_op <= PWDATA[3:0];
            lat_a   <= op_a;
            lat_b   <= op_b;
            cnt     <= CNT_LOAD;
            carry   <= 1'b0;
            op_err  <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            result <= core_res;
            carry  <= core_carry;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
